line_scheduler: RTL and testbench

Arbitrates line-draw commands from two requesters and sequences a single shared line-stepping engine. The block streams the engine's pixels to the framebuffer write port with backpressure. Off-screen pixels are clipped, and accepted pixels and completed lines are counted. It sits between the command sources (CPU port, sprite unit) and the line engine / framebuffer writer.

---
 rtl/line_scheduler.sv | 110 +++++++++++
 tb/tb_line_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scheduler.sv
// Two-requester line-draw scheduler: round-robin grant, one shared line-stepping
// engine, clipped pixel stream to the framebuffer with backpressure, pixel/line counters.
module line_scheduler #(
  parameter int             W    = 8,
  parameter int             CW   = 8,
  parameter logic [W-1:0]   XMAX = 8'd159,
  parameter logic [W-1:0]   YMAX = 8'd119
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [4*W+CW-1:0] CMD0,
  input  logic [4*W+CW-1:0] CMD1,
  output logic              ACK0,
  output logic              ACK1,
  output logic              ENG_LOAD,
  output logic [4*W-1:0]    ENG_CMD,
  output logic              ENG_STEP,
  input  logic [W-1:0]      ENG_X,
  input  logic [W-1:0]      ENG_Y,
  input  logic              ENG_LAST,
  output logic              PIX_VALID,
  output logic [W-1:0]      PIX_X,
  output logic [W-1:0]      PIX_Y,
  output logic [CW-1:0]     PIX_COLOR,
  input  logic              PIX_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       PIX_CNT,
  output logic [15:0]       LINE_CNT
);
  localparam int CMDW = 4*W + CW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW} state_t;

  state_t            r_state;
  logic [CMDW-1:0]   r_cmd;
  logic              r_rr;
  logic              r_ack0, r_ack1, r_done;
  logic [15:0]       r_pix_cnt, r_line_cnt;

  logic w_idle, w_draw, w_gnt0, w_gnt1, w_vis, w_pix_valid, w_consume;

  assign w_idle = (r_state == S_IDLE);
  assign w_draw = (r_state == S_DRAW);

  // rr picks the winner only on contention; a lone request always wins
  assign w_gnt0 = w_idle && REQ0 && (!REQ1 || !r_rr);
  assign w_gnt1 = w_idle && REQ1 && (!REQ0 ||  r_rr);

  assign w_vis       = (ENG_X <= XMAX) && (ENG_Y <= YMAX);
  assign w_pix_valid = w_draw && w_vis;
  // clipped pixels are dropped without waiting on the framebuffer
  assign w_consume   = w_draw && (!w_vis || PIX_READY);

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_rr       <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_done     <= 1'b0;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_done <= 1'b0;
      if (w_pix_valid && PIX_READY)
        r_pix_cnt <= r_pix_cnt + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_cmd     <= w_gnt0 ? CMD0 : CMD1;
            r_pix_cnt <= '0;
            r_ack0    <= w_gnt0;
            r_ack1    <= w_gnt1;
            r_rr      <= w_gnt0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_DRAW;
        S_DRAW: begin
          if (w_consume && ENG_LAST) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_line_cnt <= r_line_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ACK0      = r_ack0;
  assign ACK1      = r_ack1;
  assign DONE      = r_done;
  assign PIX_CNT   = r_pix_cnt;
  assign LINE_CNT  = r_line_cnt;
  assign BUSY      = !w_idle;
  assign ENG_LOAD  = (r_state == S_LOAD);
  assign ENG_CMD   = r_cmd[4*W-1:0];
  assign ENG_STEP  = w_consume && !ENG_LAST;
  assign PIX_VALID = w_pix_valid;
  assign PIX_X     = ENG_X;
  assign PIX_Y     = ENG_Y;
  assign PIX_COLOR = r_cmd[CMDW-1 -: CW];
endmodule

// File: tb/tb_line_scheduler.sv
// Directed bench for line_scheduler with a behavioural line-stepping engine
// (unit steps toward the endpoint on each axis).
module tb_line_scheduler;
  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [39:0] CMD0 = '0, CMD1 = '0;
  logic        ACK0, ACK1, ENG_LOAD, ENG_STEP, ENG_LAST;
  logic [31:0] ENG_CMD;
  logic [7:0]  ENG_X, ENG_Y, PIX_X, PIX_Y, PIX_COLOR;
  logic        PIX_VALID, PIX_READY = 1'b1, BUSY, DONE;
  logic [15:0] PIX_CNT, LINE_CNT;

  int checks = 0;
  int errors = 0;
  int n_step = 0;

  always #5 ACLK = ~ACLK;

  line_scheduler dut (
    .ACLK(ACLK), .ARST(ARST), .REQ0(REQ0), .REQ1(REQ1), .CMD0(CMD0), .CMD1(CMD1),
    .ACK0(ACK0), .ACK1(ACK1), .ENG_LOAD(ENG_LOAD), .ENG_CMD(ENG_CMD), .ENG_STEP(ENG_STEP),
    .ENG_X(ENG_X), .ENG_Y(ENG_Y), .ENG_LAST(ENG_LAST), .PIX_VALID(PIX_VALID),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_COLOR(PIX_COLOR), .PIX_READY(PIX_READY),
    .BUSY(BUSY), .DONE(DONE), .PIX_CNT(PIX_CNT), .LINE_CNT(LINE_CNT)
  );

  // engine model
  logic [7:0] ex = 0, ey = 0, tx = 0, ty = 0;
  always @(posedge ACLK) begin
    if (ENG_LOAD) begin
      ex <= ENG_CMD[31:24]; ey <= ENG_CMD[23:16];
      tx <= ENG_CMD[15:8];  ty <= ENG_CMD[7:0];
    end else if (ENG_STEP) begin
      ex <= (ex < tx) ? ex + 8'd1 : (ex > tx) ? ex - 8'd1 : ex;
      ey <= (ey < ty) ? ey + 8'd1 : (ey > ty) ? ey - 8'd1 : ey;
    end
    if (ENG_STEP) n_step++;
  end
  assign ENG_X    = ex;
  assign ENG_Y    = ey;
  assign ENG_LAST = (ex == tx) && (ey == ty);

  task automatic do_reset();
    ARST = 1'b1; REQ0 = 0; REQ1 = 0; PIX_READY = 1;
    @(negedge ACLK); @(negedge ACLK);
    ARST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge ACLK); #1;
    checks++;
    if ({ACK0, ACK1, DONE, BUSY, PIX_VALID, ENG_LOAD, ENG_STEP} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 0", {ACK0, ACK1, DONE, BUSY, PIX_VALID, ENG_LOAD, ENG_STEP});
    end
    checks++;
    if (ENG_CMD !== 32'h0 || PIX_COLOR !== 8'h0 || PIX_CNT !== 16'h0 || LINE_CNT !== 16'h0) begin
      errors++; $display("FAIL reset_regs got cmd=%h col=%h pc=%0d lc=%0d want 0", ENG_CMD, PIX_COLOR, PIX_CNT, LINE_CNT);
    end
    ARST = 1'b0;
  endtask

  task automatic test_basic_line();
    int s0;
    @(negedge ACLK);
    s0 = n_step;
    REQ0 = 1; CMD0 = {8'h0F, 8'd0, 8'd0, 8'd3, 8'd0};
    @(negedge ACLK); #1;
    checks++;
    if (ACK0 !== 1 || ACK1 !== 0 || ENG_LOAD !== 1 || ENG_CMD !== 32'h0000_0300) begin
      errors++; $display("FAIL basic_grant got ack0=%b ack1=%b load=%b cmd=%h want 1 0 1 00000300", ACK0, ACK1, ENG_LOAD, ENG_CMD);
    end
    REQ0 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK); #1;
      checks++;
      if (PIX_VALID !== 1 || PIX_X !== 8'(i) || PIX_Y !== 0 || PIX_COLOR !== 8'h0F || ACK0 !== 0 || DONE !== 0) begin
        errors++; $display("FAIL basic_pix%0d got v=%b (%0d,%0d) c=%h ack0=%b done=%b want 1 (%0d,0) 0f 0 0",
                           i, PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, ACK0, DONE, i);
      end
    end
    @(negedge ACLK); #1;
    checks++;
    if (DONE !== 1 || PIX_CNT !== 16'd4 || LINE_CNT !== 16'd1 || BUSY !== 0 || PIX_VALID !== 0) begin
      errors++; $display("FAIL basic_done got done=%b pc=%0d lc=%0d busy=%b v=%b want 1 4 1 0 0", DONE, PIX_CNT, LINE_CNT, BUSY, PIX_VALID);
    end
    checks++;
    if (n_step - s0 != 3) begin
      errors++; $display("FAIL basic_steps got %0d want 3", n_step - s0);
    end
  endtask

  task automatic test_round_robin();
    int order[4];
    int nack = 0;
    logic [39:0] c0, c1;
    c0 = {8'hA0, 8'd1, 8'd1, 8'd1, 8'd1};
    c1 = {8'hB1, 8'd2, 8'd2, 8'd2, 8'd2};
    do_reset();
    for (int i = 0; i < 4; i++) order[i] = -1;
    REQ0 = 1; REQ1 = 1; CMD0 = c0; CMD1 = c1;
    for (int k = 0; k < 60; k++) begin
      @(negedge ACLK); #1;
      if (ACK0 || ACK1) begin
        checks++;
        if ((ACK0 && ACK1) || !ENG_LOAD || ENG_CMD !== (ACK1 ? c1[31:0] : c0[31:0])) begin
          errors++; $display("FAIL rr_ack_cycle got ack0=%b ack1=%b load=%b cmd=%h", ACK0, ACK1, ENG_LOAD, ENG_CMD);
        end
        if (nack < 4) order[nack] = ACK1 ? 1 : 0;
        nack++;
        if (nack == 4) begin REQ0 = 0; REQ1 = 0; end
      end
      if (nack >= 4 && DONE) break;
    end
    checks++;
    if (nack != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      errors++; $display("FAIL rr_order got n=%0d %0d,%0d,%0d,%0d want 4 0,1,0,1", nack, order[0], order[1], order[2], order[3]);
    end
    checks++;
    if (LINE_CNT !== 16'd4) begin
      errors++; $display("FAIL rr_line_cnt got %0d want 4", LINE_CNT);
    end
  endtask

  task automatic test_backpressure();
    int draw = 0;
    int s0;
    @(negedge ACLK);
    REQ1 = 1; CMD1 = {8'h55, 8'd0, 8'd0, 8'd2, 8'd2};
    @(negedge ACLK); #1;
    s0 = n_step;
    checks++;
    if (ACK1 !== 1 || ENG_LOAD !== 1) begin
      errors++; $display("FAIL bp_grant got ack1=%b load=%b want 1 1", ACK1, ENG_LOAD);
    end
    REQ1 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ACLK);
      PIX_READY = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
      #1;
      if (!BUSY) break;
      draw++;
      if (k >= 1 && k <= 3) begin
        checks++;
        if (PIX_VALID !== 1 || PIX_X !== 8'd1 || PIX_Y !== 8'd1 || PIX_COLOR !== 8'h55 || ENG_STEP !== 0) begin
          errors++; $display("FAIL bp_hold%0d got v=%b (%0d,%0d) c=%h step=%b want 1 (1,1) 55 0",
                             k, PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, ENG_STEP);
        end
      end
    end
    PIX_READY = 1;
    checks++;
    if (draw != 6 || DONE !== 1 || PIX_CNT !== 16'd3 || n_step - s0 != 2) begin
      errors++; $display("FAIL bp_len got draw=%0d done=%b pc=%0d steps=%0d want 6 1 3 2", draw, DONE, PIX_CNT, n_step - s0);
    end
  endtask

  task automatic test_clipping();
    int nvis = 0;
    int draw = 0;
    int xs[2];
    xs[0] = -1; xs[1] = -1;
    @(negedge ACLK);
    REQ0 = 1; CMD0 = {8'h77, 8'd158, 8'd5, 8'd161, 8'd5};
    @(negedge ACLK);
    REQ0 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ACLK); #1;
      if (!BUSY) break;
      draw++;
      if (PIX_VALID) begin
        if (nvis < 2) xs[nvis] = int'(PIX_X);
        nvis++;
      end
    end
    checks++;
    if (nvis != 2 || xs[0] != 158 || xs[1] != 159) begin
      errors++; $display("FAIL clip_pixels got n=%0d x=%0d,%0d want 2 158,159", nvis, xs[0], xs[1]);
    end
    checks++;
    if (draw != 4 || DONE !== 1 || PIX_CNT !== 16'd2) begin
      errors++; $display("FAIL clip_done got draw=%0d done=%b pc=%0d want 4 1 2", draw, DONE, PIX_CNT);
    end
  endtask

  task automatic test_degenerate();
    int s0;
    @(negedge ACLK);
    REQ1 = 1; CMD1 = {8'h99, 8'd7, 8'd7, 8'd7, 8'd7};
    s0 = n_step;
    @(negedge ACLK);
    REQ1 = 0;
    @(negedge ACLK); #1;
    checks++;
    if (PIX_VALID !== 1 || PIX_X !== 8'd7 || PIX_Y !== 8'd7 || PIX_COLOR !== 8'h99 || ENG_STEP !== 0) begin
      errors++; $display("FAIL degen_pix got v=%b (%0d,%0d) c=%h step=%b want 1 (7,7) 99 0", PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, ENG_STEP);
    end
    @(negedge ACLK); #1;
    checks++;
    if (DONE !== 1 || PIX_CNT !== 16'd1 || n_step != s0) begin
      errors++; $display("FAIL degen_done got done=%b pc=%0d steps=%0d want 1 1 0", DONE, PIX_CNT, n_step - s0);
    end
    @(negedge ACLK); #1;
    checks++;
    if (DONE !== 0) begin
      errors++; $display("FAIL degen_pulse got done=%b want 0", DONE);
    end
  endtask

  task automatic test_reset_midline();
    int ndone = 0;
    @(negedge ACLK);
    REQ0 = 1; CMD0 = {8'h11, 8'd0, 8'd0, 8'd5, 8'd0};
    @(negedge ACLK);
    REQ0 = 0;
    @(negedge ACLK); @(negedge ACLK); @(negedge ACLK); #1;
    checks++;
    if (PIX_VALID !== 1 || PIX_X !== 8'd2) begin
      errors++; $display("FAIL mid_pix3 got v=%b x=%0d want 1 2", PIX_VALID, PIX_X);
    end
    ARST = 1; #1;
    checks++;
    if (PIX_VALID !== 0 || ENG_STEP !== 0 || BUSY !== 0 || DONE !== 0 || LINE_CNT !== 16'd0 || PIX_CNT !== 16'd0) begin
      errors++; $display("FAIL mid_reset got v=%b step=%b busy=%b done=%b lc=%0d pc=%0d want 0 0 0 0 0 0",
                         PIX_VALID, ENG_STEP, BUSY, DONE, LINE_CNT, PIX_CNT);
    end
    @(negedge ACLK);
    ARST = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK); #1;
      if (DONE || BUSY) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++; $display("FAIL mid_no_done got %0d active cycles want 0", ndone);
    end
    REQ1 = 1; CMD1 = {8'h33, 8'd9, 8'd9, 8'd9, 8'd9};
    @(negedge ACLK); #1;
    checks++;
    if (ACK1 !== 1 || ACK0 !== 0 || ENG_LOAD !== 1 || ENG_CMD !== 32'h0909_0909) begin
      errors++; $display("FAIL mid_regrant got ack1=%b ack0=%b load=%b cmd=%h want 1 0 1 09090909", ACK1, ACK0, ENG_LOAD, ENG_CMD);
    end
    REQ1 = 0;
    @(negedge ACLK); #1;
    checks++;
    if (PIX_VALID !== 1 || PIX_X !== 8'd9 || PIX_Y !== 8'd9 || PIX_COLOR !== 8'h33) begin
      errors++; $display("FAIL mid_pix got v=%b (%0d,%0d) c=%h want 1 (9,9) 33", PIX_VALID, PIX_X, PIX_Y, PIX_COLOR);
    end
    @(negedge ACLK); #1;
    checks++;
    if (DONE !== 1 || LINE_CNT !== 16'd1 || PIX_CNT !== 16'd1) begin
      errors++; $display("FAIL mid_done got done=%b lc=%0d pc=%0d want 1 1 1", DONE, LINE_CNT, PIX_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_round_robin();
    test_backpressure();
    test_clipping();
    test_degenerate();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
